// File: rtl/aes_key_schedule_controller_pkg.sv
// aes_pkg: shared types and sizing for the AES-128 key-schedule controller
package aes_pkg;
  localparam int AES_NUM_ROUNDS  = 10;
  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_WORD_BYTES  = 4;
  localparam int AES_CNT_W       = 4;
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} ksc_state_t;
endpackage

// File: rtl/aes_key_schedule_controller_if.sv
// aes_key_schedule_controller_if: handshake and strobe bundle between cipher control and the key-schedule sequencer
interface aes_key_schedule_controller_if;
  logic       start;
  logic       hold;
  logic       busy;
  logic       done;
  logic [3:0] round_counter;
  logic       read_key_in;
  logic       en_rot_word;
  logic       en_rcon;
  logic       add_modified_last_word_to_r0;
  logic       add_new_word_to_r4;
  logic       key_byte_valid;
  logic       err;
  modport master (
    output start, hold,
    input  busy, done, round_counter, read_key_in, en_rot_word, en_rcon,
           add_modified_last_word_to_r0, add_new_word_to_r4, key_byte_valid, err
  );
  modport slave (
    input  start, hold,
    output busy, done, round_counter, read_key_in, en_rot_word, en_rcon,
           add_modified_last_word_to_r0, add_new_word_to_r4, key_byte_valid, err
  );
endinterface

// File: rtl/aes_key_schedule_controller_seq_counter.sv
// aes_ksc_seq_counter: byte counter (mod BLOCK_BYTES) cascaded into a saturating round counter
module aes_ksc_seq_counter
  import aes_pkg::*;
#(
  parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
  parameter int NUM_ROUNDS  = AES_NUM_ROUNDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 hold,
  output logic [AES_CNT_W-1:0] byte_cnt,
  output logic [AES_CNT_W-1:0] round,
  output logic                 last_byte
);
  assign last_byte = byte_cnt == AES_CNT_W'(BLOCK_BYTES - 1);
  // byte wrap bumps the round on the same edge; round stops at NUM_ROUNDS
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_cnt <= '0;
      round    <= '0;
    end else if (en && !hold) begin
      byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
      if (last_byte && round != AES_CNT_W'(NUM_ROUNDS)) round <= round + 1'b1;
    end
  end
endmodule

// File: rtl/aes_key_schedule_controller.sv
// aes_key_schedule_controller: byte-serial AES-128 key-schedule sequencer (optional sticky err via AES_KSC_ERR_EN)
module aes_key_schedule_controller
  import aes_pkg::*;
(
  input logic clk,
  input logic rst,
  aes_key_schedule_controller_if.slave bus
);
  ksc_state_t state, state_n;
  logic [AES_CNT_W-1:0] byte_cnt, round;
  logic last_byte, run, adv, in_exp, win;
  aes_ksc_seq_counter #(.BLOCK_BYTES(AES_BLOCK_BYTES), .NUM_ROUNDS(AES_NUM_ROUNDS)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (!run),
    .en        (run),
    .hold      (bus.hold),
    .byte_cnt  (byte_cnt),
    .round     (round),
    .last_byte (last_byte)
  );
  // sequencing advances only while active and not stalled by the cipher
  always_comb begin
    run     = state == LOAD || state == EXPAND;
    adv     = run && !bus.hold;
    in_exp  = state == EXPAND;
    win     = byte_cnt < AES_CNT_W'(AES_WORD_BYTES);
    state_n = state == IDLE   ? (bus.start ? LOAD : IDLE) :
              state == LOAD   ? ((adv && last_byte) ? EXPAND : LOAD) :
              state == EXPAND ? ((adv && last_byte && round == AES_CNT_W'(AES_NUM_ROUNDS)) ? DONE : EXPAND) :
                                IDLE;
  end
  // state register; reset aborts any run without a done pulse
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // strobe decode from registered state and counters, silenced during hold
  always_comb begin
    bus.busy                         = run;
    bus.done                         = state == DONE;
    bus.round_counter                = run ? round : '0;
    bus.read_key_in                  = adv && state == LOAD;
    bus.key_byte_valid               = adv;
    bus.en_rot_word                  = adv && in_exp && win;
    bus.add_modified_last_word_to_r0 = adv && in_exp && win;
    bus.en_rcon                      = adv && in_exp && byte_cnt == '0;
    bus.add_new_word_to_r4           = adv && in_exp && !win;
  end
`ifdef AES_KSC_ERR_EN
  logic err_q;
  // sticky flag for a start that arrives while not idle; an accepted start clears it
  always_ff @(posedge clk) begin
    if (rst)            err_q <= 1'b0;
    else if (bus.start) err_q <= state != IDLE;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_aes_key_schedule_controller.sv
// tb_aes_key_schedule_controller: cycle model plus per-run scoreboard for the key-schedule sequencer
module tb_aes_key_schedule_controller;
  logic clk, rst;
  aes_key_schedule_controller_if bus();
  aes_key_schedule_controller dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int rcon; int rot; int r4; int kbv; int rcsum;} run_t;
  run_t sbq[$];
  int checks, errors;
  int m_a, c_rcon, c_rot, c_r4, c_kbv, c_rcsum;
  bit m_act, m_done, m_err;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] exp_vec(input logic h);
    logic en, ex;
    logic [3:0] rc;
    logic e;
    en = m_act && !h;
    ex = en && m_a >= 16;
    rc = (m_act && m_a >= 16) ? 4'((m_a - 16) / 16 + 1) : 4'd0;
`ifdef AES_KSC_ERR_EN
    e = m_err;
`else
    e = 1'b0;
`endif
    return {m_act, m_done, rc, en && m_a < 16, ex && (m_a % 16) < 4, ex && (m_a % 16) == 0,
            ex && (m_a % 16) < 4, ex && (m_a % 16) >= 4, en, e};
  endfunction

  function automatic void clr_cnt();
    c_rcon = 0; c_rot = 0; c_r4 = 0; c_kbv = 0; c_rcsum = 0;
  endfunction

  task automatic cyc(input logic s, input logic h, input logic r);
    run_t e;
    bus.start = s;
    bus.hold  = h;
    rst       = r;
    @(negedge clk);
    check("outs", {bus.busy, bus.done, bus.round_counter, bus.read_key_in, bus.en_rot_word, bus.en_rcon,
                   bus.add_modified_last_word_to_r0, bus.add_new_word_to_r4, bus.key_byte_valid, bus.err},
          exp_vec(h));
    c_rcon += int'(bus.en_rcon);
    c_rot  += int'(bus.en_rot_word);
    c_r4   += int'(bus.add_new_word_to_r4);
    c_kbv  += int'(bus.key_byte_valid);
    if (bus.en_rcon) c_rcsum += int'(bus.round_counter);
    if (bus.done === 1'b1) begin
      if (sbq.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sbq.pop_front();
        check("sb_rcon", c_rcon, e.rcon);
        check("sb_rot", c_rot, e.rot);
        check("sb_r4", c_r4, e.r4);
        check("sb_kbv", c_kbv, e.kbv);
        check("sb_rcsum", c_rcsum, e.rcsum);
      end
      clr_cnt();
    end
    @(posedge clk);
    if (r) begin
      m_act = 0; m_done = 0; m_err = 0; m_a = 0;
      sbq.delete();
      clr_cnt();
    end else if (m_done) begin
      m_done = 0;
      if (s) m_err = 1;
    end else if (m_act) begin
      if (s) m_err = 1;
      if (!h) begin
        if (m_a == 175) begin m_act = 0; m_done = 1; end
        else m_a++;
      end
    end else if (s) begin
      m_act = 1; m_a = 0; m_err = 0;
      sbq.push_back('{10, 40, 120, 176, 55});
      clr_cnt();
    end
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_act = 0; m_done = 0; m_err = 0; m_a = 0;
    clr_cnt();
    bus.start = 1; bus.hold = 0; rst = 1;
    @(posedge clk);
    #1;
    cyc(1, 0, 1);
    cyc(0, 1, 1);
    // plain run
    cyc(1, 0, 0);
    repeat (185) cyc(0, 0, 0);
    // hold for 5 cycles at round 3 byte 2
    cyc(1, 0, 0);
    repeat (50) cyc(0, 0, 0);
    repeat (5) cyc(0, 1, 0);
    repeat (140) cyc(0, 0, 0);
    // stray starts mid-run and in DONE
    cyc(1, 0, 0);
    for (int i = 1; i <= 190; i++) cyc(i == 50 || m_done, 0, 0);
    // accepted start clears err; reset at round 6 byte 9
    cyc(1, 0, 0);
    repeat (105) cyc(0, 0, 0);
    cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    // full run with random stalls after the abort
    cyc(1, 0, 0);
    repeat (260) cyc(0, $urandom_range(0, 7) == 0, 0);
    repeat (3) cyc(0, 1, 0);
    check("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
